// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequences the PC, fetches over a req/ack handshake
// to instruction memory and hands each word to decode under a valid/stall handshake.
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [7:0]      HALT_OP  = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic              halted,
  output logic [15:0]       retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DELIVER,
    S_HALTED
  } state_t;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [PC_W-1:0]   drain_addr_reg, drain_addr_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [INST_W-1:0] inst_reg, inst_next;
  logic [15:0]       retired_reg, retired_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      fetch_pc_reg   <= RESET_PC;
      drain_addr_reg <= RESET_PC;
      pc_reg         <= RESET_PC;
      inst_reg       <= '0;
      retired_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      drain_addr_reg <= drain_addr_next;
      pc_reg         <= pc_next;
      inst_reg       <= inst_next;
      retired_reg    <= retired_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    drain_addr_next = drain_addr_reg;
    pc_next         = pc_reg;
    inst_next       = inst_reg;
    retired_next    = retired_reg;
    case (state_reg)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        if (br_taken) begin
          // A same-cycle ack is dropped; otherwise the bus request must still finish.
          fetch_pc_next = br_target;
          if (!imem_ack) begin
            drain_addr_next = fetch_pc_reg;
            state_next      = S_DRAIN;
          end
        end else if (imem_ack) begin
          inst_next     = imem_rdata;
          pc_next       = fetch_pc_reg;
          fetch_pc_next = fetch_pc_reg + PC_W'(1);
          state_next    = S_DELIVER;
        end
      end
      S_DRAIN: begin
        if (br_taken) fetch_pc_next = br_target;
        if (imem_ack) state_next = S_FETCH;
      end
      S_DELIVER: begin
        if (br_taken) begin
          fetch_pc_next = br_target;
          state_next    = S_FETCH;
        end else if (!stall) begin
          retired_next = retired_reg + 16'd1;
          state_next   = (inst_reg[INST_W-1 -: 8] == HALT_OP) ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign imem_req   = (state_reg == S_FETCH) || (state_reg == S_DRAIN);
  assign imem_addr  = (state_reg == S_DRAIN) ? drain_addr_reg : fetch_pc_reg;
  assign inst_valid = (state_reg == S_DELIVER);
  assign halted     = (state_reg == S_HALTED);
  assign pc         = pc_reg;
  assign inst       = inst_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: one table row per clock cycle,
// plus a hand-written asynchronous-reset sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [7:0]  pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        halted;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack, stall, br;
    logic [7:0]  tgt;
    logic        halt1;   // memory word 1 carries the halt opcode
    logic        req;
    logic [7:0]  addr;
    logic        valid;
    logic [7:0]  pc;
    logic [15:0] ret;
    logic        halted;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mem_word(input logic [7:0] a, input logic halt1);
    logic [7:0] op;
    op = (halt1 && a == 8'h01) ? 8'hFF : 8'h01;
    return {op, a, 8'(a + 8'd1), 8'(a + 8'd2)};
  endfunction

  function automatic vec_t mk(input logic ack, stall_i, br, input logic [7:0] tgt,
                              input logic halt1, req, input logic [7:0] addr,
                              input logic valid, input logic [7:0] pc_e,
                              input logic [15:0] ret, input logic hlt);
    vec_t v;
    v.ack = ack; v.stall = stall_i; v.br = br; v.tgt = tgt; v.halt1 = halt1;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc_e; v.ret = ret; v.halted = hlt;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"},     -1, 32'(imem_req),   32'd0);
    chk({tag, "_addr"},    -1, 32'(imem_addr),  32'd0);
    chk({tag, "_pc"},      -1, 32'(pc),         32'd0);
    chk({tag, "_inst"},    -1, inst,            32'd0);
    chk({tag, "_valid"},   -1, 32'(inst_valid), 32'd0);
    chk({tag, "_halted"},  -1, 32'(halted),     32'd0);
    chk({tag, "_retired"}, -1, 32'(retired),    32'd0);
  endtask

  initial begin
    // ---- cycle-by-cycle expectations ----
    tbl.push_back(mk(0,0,0,8'h00,0, 0,8'h00,0,8'h00,16'd0,0));              // IDLE
    for (int i = 0; i < 10; i++) begin                                      // zero-wait stream
      tbl.push_back(mk(1,0,0,8'h00,0, 1,8'(i),0,(i == 0) ? 8'h00 : 8'(i - 1),16'(i),0));
      tbl.push_back(mk(0,0,0,8'h00,0, 0,8'(i + 1),1,8'(i),16'(i),0));
    end
    tbl.push_back(mk(0,0,0,8'h00,0, 1,8'h0A,0,8'h09,16'd10,0));             // 2 wait states
    tbl.push_back(mk(0,0,0,8'h00,0, 1,8'h0A,0,8'h09,16'd10,0));
    tbl.push_back(mk(1,0,0,8'h00,0, 1,8'h0A,0,8'h09,16'd10,0));
    for (int i = 0; i < 4; i++)                                             // 4-cycle stall
      tbl.push_back(mk(0,1,0,8'h00,0, 0,8'h0B,1,8'h0A,16'd10,0));
    tbl.push_back(mk(0,0,0,8'h00,0, 0,8'h0B,1,8'h0A,16'd10,0));
    tbl.push_back(mk(1,0,0,8'h00,0, 1,8'h0B,0,8'h0A,16'd11,0));
    tbl.push_back(mk(0,0,1,8'h05,0, 0,8'h0C,1,8'h0B,16'd11,0));             // flush pc 0B
    tbl.push_back(mk(1,0,0,8'h00,0, 1,8'h05,0,8'h0B,16'd11,0));
    tbl.push_back(mk(0,0,1,8'h40,0, 0,8'h06,1,8'h05,16'd11,0));             // branch at pc 5
    tbl.push_back(mk(1,0,0,8'h00,0, 1,8'h40,0,8'h05,16'd11,0));
    tbl.push_back(mk(0,1,1,8'h03,0, 0,8'h41,1,8'h40,16'd11,0));             // branch under stall
    tbl.push_back(mk(0,0,1,8'h20,0, 1,8'h03,0,8'h40,16'd11,0));             // branch while waiting
    tbl.push_back(mk(0,0,0,8'h00,0, 1,8'h03,0,8'h40,16'd11,0));             // drain
    tbl.push_back(mk(1,0,0,8'h00,0, 1,8'h03,0,8'h40,16'd11,0));             // drain ack discarded
    tbl.push_back(mk(1,0,1,8'hFE,1, 1,8'h20,0,8'h40,16'd11,0));             // branch with ack
    tbl.push_back(mk(1,0,0,8'h00,1, 1,8'hFE,0,8'h40,16'd11,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 0,8'hFF,1,8'hFE,16'd11,0));
    tbl.push_back(mk(1,0,0,8'h00,1, 1,8'hFF,0,8'hFE,16'd12,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 0,8'h00,1,8'hFF,16'd12,0));             // wrap
    tbl.push_back(mk(1,0,0,8'h00,1, 1,8'h00,0,8'hFF,16'd13,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 0,8'h01,1,8'h00,16'd13,0));
    tbl.push_back(mk(1,0,0,8'h00,1, 1,8'h01,0,8'h00,16'd14,0));
    tbl.push_back(mk(0,0,0,8'h00,1, 0,8'h02,1,8'h01,16'd14,0));             // halt opcode
    for (int i = 0; i < 3; i++)                                             // halted, inputs ignored
      tbl.push_back(mk(1,0,1,8'h30,1, 0,8'h02,0,8'h01,16'd15,1));

    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; br_taken = 1'b0; br_target = '0;
    repeat (2) @(negedge clk);
    #1 chk_reset_values("init");
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      if (i > 0) @(negedge clk);
      imem_ack   = tbl[i].ack;
      stall      = tbl[i].stall;
      br_taken   = tbl[i].br;
      br_target  = tbl[i].tgt;
      imem_rdata = mem_word(imem_addr, tbl[i].halt1);
      #1;
      chk("req",     i, 32'(imem_req),   32'(tbl[i].req));
      chk("addr",    i, 32'(imem_addr),  32'(tbl[i].addr));
      chk("valid",   i, 32'(inst_valid), 32'(tbl[i].valid));
      chk("pc",      i, 32'(pc),         32'(tbl[i].pc));
      chk("retired", i, 32'(retired),    32'(tbl[i].ret));
      chk("halted",  i, 32'(halted),     32'(tbl[i].halted));
      if (tbl[i].valid) chk("inst", i, inst, mem_word(tbl[i].pc, tbl[i].halt1));
      $display("cycle %0d: req=%b addr=%h valid=%b pc=%h ret=%0d halted=%b",
               i, imem_req, imem_addr, inst_valid, pc, retired, halted);
    end

    // ---- asynchronous reset in the middle of a fetch ----
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0; stall = 1'b0; br_taken = 1'b0;
    #1 chk_reset_values("halt_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);                                   // FETCH at RESET_PC, no ack yet
    #1 chk("mid_req", -1, 32'(imem_req), 32'd1);
    #2 reset = 1'b0;
    #1 chk_reset_values("async");
    imem_ack = 1'b1; imem_rdata = mem_word(8'h00, 1'b0);
    @(negedge clk);                                   // ack under reset must be ignored
    #1 chk_reset_values("ack_in_rst");
    reset = 1'b1; imem_ack = 1'b0;
    #1 chk("restart_idle_req", -1, 32'(imem_req), 32'd0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr, 1'b0);
    #1;
    chk("restart_req",  -1, 32'(imem_req),  32'd1);
    chk("restart_addr", -1, 32'(imem_addr), 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk("restart_valid", -1, 32'(inst_valid), 32'd1);
    chk("restart_pc",    -1, 32'(pc),         32'd0);
    chk("restart_inst",  -1, inst,            mem_word(8'h00, 1'b0));
    $display("restart: valid=%b pc=%h inst=%h", inst_valid, pc, inst);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch front end: generates the program counter and drives it into instruction memory over a req/ack handshake.
- Captures the returned 32-bit instruction and presents it, with its PC, to the decode/execute datapath under a valid/stall handshake.
- Handles taken branches and a halt opcode.
- Replaces testbench-driven PC sequencing, so the processor runs a program autonomously.

## Interface

Parameters:
- PC_W, 8, PC and instruction-memory address width
- INST_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- HALT_OP, 8'hFF, opcode (inst[31:24]) that halts fetch

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  PC_W  fetch address; stable while imem_req=1
- imem_ack  input  1  memory has imem_rdata valid this cycle
- imem_rdata  input  INST_W  instruction word, sampled when imem_req & imem_ack
- pc  output  PC_W  address of the instruction on inst
- inst  output  INST_W  fetched instruction (opcode [31:24], insa [23:16], insb [15:8], write_back [7:0])
- inst_valid  output  1  inst/pc valid for decode
- stall  input  1  decode cannot accept; holds inst_valid word
- br_taken  input  1  single-cycle redirect request
- br_target  input  PC_W  redirect address, sampled with br_taken
- halted  output  1  HALT_OP consumed; fetch stopped
- retired  output  16  count of consumed instructions, wraps at 65535->0

## Operation

- Internal fetch_pc register. States: IDLE, FETCH, DRAIN, DELIVER, HALTED.
- Reset (reset=0): state IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, inst=0, inst_valid=0, halted=0, retired=0.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - imem_req=1, imem_addr=fetch_pc, both held until imem_ack=1.
  - On ack: inst<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^PC_W; 255 wraps to 0), go DELIVER.
- DELIVER:
  - inst_valid=1, imem_req=0.
  - Consumed when inst_valid & !stall: retired+1, then FETCH.
  - If inst[31:24]==HALT_OP, go HALTED instead of FETCH.
  - With stall=1, inst/pc hold unchanged.
- Branch (br_taken=1; ignored in IDLE and HALTED; priority over stall and ack):
  - FETCH without ack: the outstanding request must complete. Set fetch_pc<=br_target, go DRAIN.
  - FETCH with ack the same cycle: discard rdata (no inst_valid), fetch_pc<=br_target, stay FETCH.
  - DRAIN: imem_req=1 at old address until ack. Data is discarded, then FETCH at the target. A second branch in DRAIN overwrites fetch_pc.
  - DELIVER: flush. inst_valid=0 next cycle, no retire, fetch_pc<=br_target, go FETCH. Also applies when stall=1.
- HALTED: imem_req=0, inst_valid=0, halted=1. Only reset exits.
- Reset asserted mid-handshake aborts immediately. imem_req drops asynchronously and a pending ack is ignored.

## Timing

- Cycle 0 = first rising edge with reset=1: IDLE. imem_req=1 from cycle 1.
- Ack in cycle k (req high in k) -> inst_valid=1 in cycle k+1.
- Consume in cycle m -> imem_req=1 in cycle m+1.
- Zero-wait memory (ack same cycle as req) gives 2 cycles per instruction.
- Branch in cycle b:
  - From DELIVER: imem_req at br_target in b+1.
  - From FETCH with same-cycle ack: imem_addr = br_target in b+1.
- All outputs are registered. No combinational path from any input to any output.

## Test plan

- Reset/sequential:
  - Memory: word i = {8'h01, i, i+1, i+2}, zero-wait ack, stall=0.
  - Required: imem_addr 0,1,2,… on alternate cycles; inst_valid every 2nd cycle with pc 0,1,2,…
  - After 10 instructions, retired=10.
- Wait states and stall:
  - Ack 3 cycles after req: imem_addr held stable for all 3 cycles.
  - stall=1 for 4 cycles while inst_valid: inst/pc unchanged, imem_req=0, retired unchanged until release.
- Branch in DELIVER:
  - At pc=5, br_taken=1, br_target=8'h40.
  - Required: pc 5 not retired, inst_valid=0 next cycle, next imem_addr=8'h40, next delivered pc=8'h40.
- Branch during wait:
  - br_taken (target 8'h20) while req at addr 3 awaits ack; ack 2 cycles later.
  - Required: addr 3 held until ack, its data never valid, next imem_addr=8'h20.
- Wrap and halt:
  - Start fetch at 8'hFE via branch; word at 8'h01 has opcode 8'hFF.
  - Required: pcs FE, FF, 00, 01, then halted=1, imem_req=0, inst_valid=0 permanently.
- Async reset:
  - Drop reset mid-FETCH between clock edges.
  - Required: imem_req=0 and all outputs at reset values before the next edge; restart from RESET_PC after release.
